sseg_scroll_msg: RTL and testbench
==================================

Name: sseg_scroll_msg

Overview:
Upstream pattern source for the 4-digit seven-segment display path. It buffers a short hex message loaded over a valid/ready write port, then scrolls it across the four digits at a prescaled rate. Direction is set by cw; scrolling pauses while en is low. Output is the packed 28-bit segment word consumed by the digit mux stage: digit 3 (leftmost) in bits [27:21], digit 0 (rightmost) in bits [6:0].

Parameters:
- DEPTH, 8, message buffer capacity in hex nibbles (range 4..16).
- TICK_DIV, 25_000_000, clk cycles per scroll step while en=1 (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  scroll enable; low freezes the prescaler and position.
- cw  input  1  scroll direction; 1 = position +1 per step, 0 = position -1 per step.
- clear  input  1  synchronous abort to IDLE; buffer length zeroed.
- wr_valid  input  1  write request.
- wr_data  input  4  hex nibble to append.
- wr_last  input  1  qualifies the final nibble of a message.
- wr_ready  output  1  write acceptance.
- scrolling  output  1  high in SCROLL.
- ssegValues  output  28  packed segments, active-low, per digit bit6=g .. bit0=a.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, len=0, wr_ptr=0, pos=0, prescaler=0, ssegValues=28'hFFFFFFF (all blank), wr_ready=1, scrolling=0.
- A write is accepted when wr_valid && wr_ready. An accepted nibble is stored at buf[wr_ptr], then wr_ptr increments.
- IDLE: wr_ready=1; display all blank. The first accepted write moves the block to LOAD, or straight to SCROLL if wr_last=1 on that write (len=1).
- LOAD: wr_ready=1. The block moves to SCROLL on an accepted write with wr_last=1, or on the write that fills DEPTH entries (auto-terminate).
  - On that transition: len=wr_ptr+1, pos=0, prescaler=0.
- SCROLL: wr_ready=0; scrolling=1.
  - When en=1, the prescaler counts from 0 to TICK_DIV-1, then wraps and issues a one-cycle tick.
  - On a tick: pos = (pos+1) mod len if cw=1; pos = (pos-1+len) mod len if cw=0.
  - pos wraps from len-1 to 0 and from 0 to len-1.
- Display mapping: digit k (k=3 leftmost down to 0) shows buf[(pos+3-k) mod len], hex-decoded.
  - For len<4, indices wrap, so the message repeats across the digits.
- Latency: ssegValues is registered and reflects a new pos or state one cycle after the change.
- clear=1 in any state: next cycle state=IDLE, len=0, wr_ptr=0, pos=0, prescaler=0, display blank.
  - clear has priority over a simultaneous write, which is dropped.
  - clear has priority over a simultaneous tick.
- A cw change mid-run takes effect on the next tick; the prescaler is not reset.
- en low holds the prescaler value; on resume, counting continues from the held value.
- Hex decode (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Optional Feature:
- Macro: SSEG_SCROLL_BLANK_EN.
- Defined: a blank separator slot is appended after the message. The effective scroll length is len+1, and slot index len displays 7'h7F. Buffer storage is unchanged, and the slot is not writable.
- Undefined: the effective length is len; no separator.

Decomposition:
- Package sseg_scroll_pkg holds:
  - state enum {IDLE, LOAD, SCROLL};
  - SEG_BLANK = 7'h7F;
  - the 16-entry hex-to-segment constant table.
- Sub-module hex_to_sseg: combinational 4-bit to 7-bit decoder, instantiated four times, one per digit.

Test Plan:
- Reset then release: ssegValues=28'hFFFFFFF, wr_ready=1, scrolling=0.
- TICK_DIV=4, write 1,2,3,4,5 (last on 5), en=1, cw=1:
  - first display 1,2,3,4 (ssegValues = {1111001,0100100,0110000,0011001});
  - every 4 cycles the view shifts left by one nibble;
  - after 5 ticks the view returns to 1,2,3,4.
- Same load with cw=0: first tick gives 5,1,2,3. Toggling en=0 for 10 cycles delays the next tick by exactly 10 cycles.
- Write DEPTH=8 nibbles without wr_last: auto-enters SCROLL with len=8. A 9th wr_valid sees wr_ready=0 and is not stored.
- len=2 message (A,b): display reads A,b,A,b; after one cw tick it reads b,A,b,A.
- clear asserted mid-scroll together with a tick and a wr_valid: next cycle IDLE, display blank, no write stored. With SSEG_SCROLL_BLANK_EN, a message 1,2,3 cycles through 4 positions, including blank-led views.

Source files
------------

// File: rtl/sseg_scroll_msg_pkg.sv
// Shared types and constants for the scrolling seven-segment message source.
// The SSEG_SCROLL_BLANK_EN option itself lives in sseg_scroll_msg.sv.
package sseg_scroll_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // (base + off) mod n for base < n and off <= 3.
  // Three conditional subtractions are enough even when n == 1.
  function automatic logic [4:0] wrap_idx(input logic [4:0] base,
                                          input logic [1:0] off,
                                          input logic [4:0] n);
    logic [4:0] v;
    v = base + {3'b000, off};
    for (int i = 0; i < 3; i++)
      if (v >= n) v = v - n;
    return v;
  endfunction

endpackage

// File: rtl/sseg_scroll_msg_if.sv
// Valid/ready write port carrying one hex nibble per transfer.
interface sseg_scroll_msg_if;
  logic       wr_valid;
  logic [3:0] wr_data;
  logic       wr_last;
  logic       wr_ready;

  modport master (output wr_valid, wr_data, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_last, output wr_ready);
endinterface

// File: rtl/sseg_scroll_msg_hex_to_sseg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_sseg
  import sseg_scroll_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[hex];
endmodule

// File: rtl/sseg_scroll_msg.sv
// Buffers a hex message and scrolls it across four seven-segment digits.
// Option macro SSEG_SCROLL_BLANK_EN: append one blank slot after the message.
module sseg_scroll_msg
  import sseg_scroll_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cw,
  input  logic               clear,
  sseg_scroll_msg_if.slave   wr,
  output logic               scrolling,
  output logic [27:0]        ssegValues
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(TICK_DIV);
`ifdef SSEG_SCROLL_BLANK_EN
  localparam logic [4:0] EXTRA = 5'd1;
`else
  localparam logic [4:0] EXTRA = 5'd0;
`endif

  state_t                 state;
  logic [4:0]             len, wr_ptr, pos, eff_len, next_pos;
  logic [PW-1:0]          presc;
  logic                   ready_q, wr_acc, tick, fill_done;
  logic [DEPTH-1:0][3:0]  msg_buf;
  logic [3:0][6:0]        seg_nxt;

  assign wr.wr_ready = ready_q;
  assign wr_acc      = wr.wr_valid && ready_q;
  assign fill_done   = wr.wr_last || (wr_ptr == 5'(DEPTH - 1));
  assign tick        = (state == SCROLL) && en && (presc == PW'(TICK_DIV - 1));
  assign eff_len     = len + EXTRA;
  assign next_pos    = cw ? ((pos == eff_len - 5'd1) ? 5'd0 : pos + 5'd1)
                          : ((pos == 5'd0) ? eff_len - 5'd1 : pos - 5'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len       <= '0;
      wr_ptr    <= '0;
      pos       <= '0;
      presc     <= '0;
      ready_q   <= 1'b1;
      scrolling <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      len       <= '0;
      wr_ptr    <= '0;
      pos       <= '0;
      presc     <= '0;
      ready_q   <= 1'b1;
      scrolling <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (wr_acc) begin
            wr_ptr <= wr_ptr + 5'd1;
            if (fill_done) begin
              state     <= SCROLL;
              len       <= wr_ptr + 5'd1;
              pos       <= '0;
              presc     <= '0;
              ready_q   <= 1'b0;
              scrolling <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        SCROLL: begin
          if (en) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) pos <= next_pos;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Message storage carries no reset; len gates what is ever displayed.
  always_ff @(posedge clk) begin
    if (wr_acc && !clear) msg_buf[wr_ptr[AW-1:0]] <= wr.wr_data;
  end

  for (genvar k = 0; k < 4; k++) begin : g_dig
    logic [4:0] idx;
    logic [6:0] dec;
    logic       slot_blank;

    assign idx = wrap_idx(pos, 2'(3 - k), eff_len);
    // Only the separator slot (idx == len) can land here while scrolling.
    assign slot_blank = (idx >= len);

    hex_to_sseg u_dec (
      .hex (msg_buf[idx[AW-1:0]]),
      .seg (dec)
    );

    assign seg_nxt[k] = slot_blank ? SEG_BLANK : dec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              ssegValues <= '1;
    else if (clear || state != SCROLL)     ssegValues <= '1;
    else                                   ssegValues <= seg_nxt;
  end

endmodule

// File: tb/tb_sseg_scroll_msg.sv
// Directed, table-driven bench for sseg_scroll_msg (DEPTH=8, TICK_DIV=4).
module tb_sseg_scroll_msg;
  localparam int B = 16;  // blank digit marker in expected views

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, cw = 1'b1, clear = 1'b0;
  logic        scrolling;
  logic [27:0] ssegValues;
  int          nvec = 0, nerr = 0;

  sseg_scroll_msg_if wr_if ();

  sseg_scroll_msg #(.DEPTH(8), .TICK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cw         (cw),
    .clear      (clear),
    .wr         (wr_if),
    .scrolling  (scrolling),
    .ssegValues (ssegValues)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexseg(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;
      14: return 7'b0000110; 15: return 7'b0001110;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] view(input int d3, input int d2, input int d1, input int d0);
    return {hexseg(d3), hexseg(d2), hexseg(d1), hexseg(d0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [27:0] got, input logic [27:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic write_msg(input logic [63:0] nibs, input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = nibs[4*i +: 4];
      wr_if.wr_last  = use_last && (i == n - 1);
      step();
    end
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  typedef struct {
    int          adv;
    logic [27:0] seg;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [63:0] msg;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 4'h0;
    wr_if.wr_last  = 1'b0;

`ifdef SSEG_SCROLL_BLANK_EN
    tbl[0] = '{1, view(1,2,3,4)}; tbl[1] = '{3, view(1,2,3,4)};
    tbl[2] = '{1, view(2,3,4,5)}; tbl[3] = '{4, view(3,4,5,B)};
    tbl[4] = '{4, view(4,5,B,1)}; tbl[5] = '{4, view(5,B,1,2)};
    tbl[6] = '{4, view(B,1,2,3)}; tbl[7] = '{4, view(1,2,3,4)};
`else
    tbl[0] = '{1, view(1,2,3,4)}; tbl[1] = '{3, view(1,2,3,4)};
    tbl[2] = '{1, view(2,3,4,5)}; tbl[3] = '{4, view(3,4,5,1)};
    tbl[4] = '{4, view(4,5,1,2)}; tbl[5] = '{4, view(5,1,2,3)};
    tbl[6] = '{4, view(1,2,3,4)}; tbl[7] = '{4, view(2,3,4,5)};
`endif

    // Reset state, held and after release
    repeat (3) step();
    chk("rst_seg",   ssegValues, 28'hFFFFFFF);
    chk("rst_ready", {27'd0, wr_if.wr_ready}, 28'd1);
    chk("rst_scroll", {27'd0, scrolling}, 28'd0);
    rst = 1'b1;
    step();
    chk("idle_seg", ssegValues, 28'hFFFFFFF);

    // Forward scroll of 1..5
    en = 1'b1; cw = 1'b1;
    msg = 64'h0000_0000_0005_4321;
    write_msg(msg, 5, 1'b1);
    chk("load_scroll", {27'd0, scrolling}, 28'd1);
    chk("load_ready",  {27'd0, wr_if.wr_ready}, 28'd0);
    chk("load_seg_blank", ssegValues, 28'hFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      repeat (tbl[i].adv) step();
      chk($sformatf("fwd_vec%0d", i), ssegValues, tbl[i].seg);
    end
    do_clear();

    // Reverse scroll with an en pause of 10 cycles
    cw = 1'b0;
    write_msg(msg, 5, 1'b1);
    step();
    chk("rev_first", ssegValues, view(1,2,3,4));
    repeat (4) step();
`ifdef SSEG_SCROLL_BLANK_EN
    chk("rev_tick1", ssegValues, view(B,1,2,3));
    en = 1'b0; repeat (10) step(); en = 1'b1;
    chk("rev_hold", ssegValues, view(B,1,2,3));
    repeat (3) step();
    chk("rev_pre_tick2", ssegValues, view(B,1,2,3));
    step();
    chk("rev_tick2", ssegValues, view(5,B,1,2));
`else
    chk("rev_tick1", ssegValues, view(5,1,2,3));
    en = 1'b0; repeat (10) step(); en = 1'b1;
    chk("rev_hold", ssegValues, view(5,1,2,3));
    repeat (3) step();
    chk("rev_pre_tick2", ssegValues, view(5,1,2,3));
    step();
    chk("rev_tick2", ssegValues, view(4,5,1,2));
`endif
    do_clear();

    // Auto-terminate at DEPTH; 9th write refused
    cw = 1'b1;
    msg = 64'h0000_0000_7654_3210;
    write_msg(msg, 8, 1'b0);
    wr_if.wr_valid = 1'b1; wr_if.wr_data = 4'hF;
    chk("full_ready", {27'd0, wr_if.wr_ready}, 28'd0);
    chk("full_scroll", {27'd0, scrolling}, 28'd1);
    step();
    chk("full_first", ssegValues, view(0,1,2,3));
    repeat (20) step();
    wr_if.wr_valid = 1'b0;
`ifdef SSEG_SCROLL_BLANK_EN
    chk("full_pos5", ssegValues, view(5,6,7,B));
`else
    chk("full_pos5", ssegValues, view(5,6,7,0));
`endif
    do_clear();

    // Two-nibble message wraps across the digits
    msg = 64'h0000_0000_0000_00BA;
    write_msg(msg, 2, 1'b1);
    step();
`ifdef SSEG_SCROLL_BLANK_EN
    chk("len2_pos0", ssegValues, view(10,11,B,10));
    repeat (4) step();
    chk("len2_pos1", ssegValues, view(11,B,10,11));
`else
    chk("len2_pos0", ssegValues, view(10,11,10,11));
    repeat (4) step();
    chk("len2_pos1", ssegValues, view(11,10,11,10));
`endif
    do_clear();

    // clear beats a coincident tick and write
    msg = 64'h0000_0000_0005_4321;
    write_msg(msg, 5, 1'b1);
    repeat (3) step();
    clear = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_data = 4'h9; wr_if.wr_last = 1'b1;
    step();
    clear = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
    chk("clr_seg",    ssegValues, 28'hFFFFFFF);
    chk("clr_scroll", {27'd0, scrolling}, 28'd0);
    chk("clr_ready",  {27'd0, wr_if.wr_ready}, 28'd1);
    step();
    chk("clr_idle_seg", ssegValues, 28'hFFFFFFF);
    msg = 64'h0000_0000_0000_000C;
    write_msg(msg, 1, 1'b1);
    chk("len1_scroll", {27'd0, scrolling}, 28'd1);
    step();
`ifdef SSEG_SCROLL_BLANK_EN
    chk("len1_view", ssegValues, view(12,B,12,B));
`else
    chk("len1_view", ssegValues, view(12,12,12,12));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
